// File: rtl/freq_sweep_pkg.sv
// freq_sweep_pkg: shared state encoding and default widths for the frequency sweep controller
package freq_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DWELL, HOP, FINISH} state_t;
  localparam int DEF_INC_W   = 8;
  localparam int DEF_DWELL_W = 16;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter that pulses expire on the last cycle of a dwell (0 loads as 1)
module dwell_timer
  import freq_sweep_pkg::*;
#(
  parameter int W = DEF_DWELL_W
) (
  input  logic         pll_clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge pll_clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= (value == '0) ? W'(1) : value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expire = (cnt == W'(1));
endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: stepped-frequency sweep FSM driving an NCO phase increment with per-tone dwell
module freq_sweep_ctrl
  import freq_sweep_pkg::*;
#(
  parameter int INC_W   = DEF_INC_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               pll_clock,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [INC_W-1:0]   cfg_start_inc,
  input  logic [INC_W-1:0]   cfg_stop_inc,
  input  logic [INC_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [INC_W-1:0]   phase_inc,
  output logic               nco_en,
  output logic               busy,
  output logic               done,
  output logic [7:0]         hop_count
);
  state_t state, state_d;
  logic [INC_W-1:0] sh_start, sh_stop, sh_step, phase_d;
  logic [DWELL_W-1:0] sh_dwell, load_val;
  logic sh_repeat, en_d, busy_d, done_d, load, expire, accept, fits;
  logic [7:0] hop_d;
  logic [INC_W:0] nxt;
  assign accept = cfg_valid && cfg_ready;
  assign nxt = {1'b0, phase_inc} + {1'b0, sh_step};
  assign fits = (sh_step != '0) && (nxt <= {1'b0, sh_stop});
  dwell_timer #(.W(DWELL_W)) u_timer (
    .pll_clock(pll_clock),
    .reset_n  (reset_n),
    .load     (load),
    .value    (load_val),
    .expire   (expire)
  );
  always_comb begin
    state_d  = state;
    phase_d  = phase_inc;
    en_d     = nco_en;
    busy_d   = busy;
    done_d   = 1'b0;
    hop_d    = hop_count;
    load     = 1'b0;
    load_val = sh_dwell;
    case (state)
      IDLE: if (start) begin
        state_d  = DWELL;
        phase_d  = accept ? cfg_start_inc : sh_start;
        load_val = accept ? cfg_dwell : sh_dwell;
        en_d     = 1'b1;
        busy_d   = 1'b1;
        hop_d    = '0;
        load     = 1'b1;
      end
      DWELL: state_d = expire ? HOP : DWELL;
      HOP: if (fits) begin
        state_d = DWELL;
        phase_d = nxt[INC_W-1:0];
        hop_d   = hop_count + {7'd0, hop_count != 8'hff};
        load    = 1'b1;
      end else if (sh_repeat) begin
        // step==0 re-dwells on the same tone; overflow restarts from start_inc
        state_d = DWELL;
        load    = 1'b1;
        phase_d = (sh_step != '0) ? sh_start : phase_inc;
        hop_d   = (sh_step != '0) ? 8'd0 : hop_count;
      end else begin
        state_d = FINISH;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      load    = 1'b0;
    end
  end
  always_ff @(posedge pll_clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      phase_inc <= '0;
      nco_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b0;
      hop_count <= '0;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= '0;
      sh_repeat <= 1'b0;
    end else begin
      state     <= state_d;
      phase_inc <= phase_d;
      nco_en    <= en_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_ready <= (state_d == IDLE);
      hop_count <= hop_d;
      if (accept) begin
        sh_start  <= cfg_start_inc;
        sh_stop   <= cfg_stop_inc;
        sh_step   <= cfg_step;
        sh_dwell  <= cfg_dwell;
        sh_repeat <= cfg_repeat;
      end
    end
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed self-checking bench for freq_sweep_ctrl
module tb_freq_sweep_ctrl;
  logic pll_clock, reset_n, cfg_valid, cfg_ready, cfg_repeat, start, abort;
  logic [7:0] cfg_start_inc, cfg_stop_inc, cfg_step, phase_inc, hop_count;
  logic [15:0] cfg_dwell;
  logic nco_en, busy, done;
  int n_cmp = 0, n_err = 0;

  freq_sweep_ctrl dut (
    .pll_clock    (pll_clock),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_start_inc(cfg_start_inc),
    .cfg_stop_inc (cfg_stop_inc),
    .cfg_step     (cfg_step),
    .cfg_dwell    (cfg_dwell),
    .cfg_repeat   (cfg_repeat),
    .start        (start),
    .abort        (abort),
    .phase_inc    (phase_inc),
    .nco_en       (nco_en),
    .busy         (busy),
    .done         (done),
    .hop_count    (hop_count)
  );

  initial pll_clock = 1'b0;
  always #5 pll_clock = ~pll_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pll_clock);
    #1;
  endtask

  task automatic drive_cfg(input int s, input int e, input int st, input int d, input logic r);
    cfg_start_inc = 8'(s);
    cfg_stop_inc  = 8'(e);
    cfg_step      = 8'(st);
    cfg_dwell     = 16'(d);
    cfg_repeat    = r;
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int d, input logic r);
    drive_cfg(s, e, st, d, r);
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    drive_cfg(0, 0, 0, 0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_phase", phase_inc, 0);
    chk("rst_nco", nco_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_hop", hop_count, 0);
    tick; tick;
    reset_n = 1'b1;
    chk("ready_before_edge", cfg_ready, 0);
    tick;
    chk("ready_after_edge", cfg_ready, 1);

    // single sweep 3 -> 8 -> 13, dwell 4
    set_cfg(3, 13, 5, 4, 1'b0);
    chk("a_ready_idle", cfg_ready, 1);
    go;
    chk("a_busy", busy, 1);
    chk("a_nco", nco_en, 1);
    chk("a_ready_busy", cfg_ready, 0);
    for (int i = 0; i < 15; i++) begin
      chk("a_phase", phase_inc, i < 5 ? 3 : i < 10 ? 8 : 13);
      chk("a_hop", hop_count, i / 5);
      chk("a_done_low", done, 0);
      tick;
    end
    chk("a_done_pulse", done, 1);
    chk("a_fin_busy", busy, 0);
    chk("a_fin_nco", nco_en, 0);
    chk("a_fin_phase", phase_inc, 13);
    chk("a_fin_hop", hop_count, 2);
    tick;
    chk("a_done_once", done, 0);
    chk("a_idle_ready", cfg_ready, 1);
    chk("a_hold_phase", phase_inc, 13);

    // abort in the second dwell
    go;
    repeat (5) tick;
    chk("b_second_tone", phase_inc, 8);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("b_abort_busy", busy, 0);
    chk("b_abort_nco", nco_en, 0);
    chk("b_abort_phase", phase_inc, 8);
    chk("b_abort_done", done, 0);
    chk("b_abort_ready", cfg_ready, 1);
    repeat (3) begin
      tick;
      chk("b_no_done", done, 0);
      chk("b_phase_held", phase_inc, 8);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("b_idle_abort_busy", busy, 0);
    chk("b_idle_abort_phase", phase_inc, 8);

    // continuous sweep with carry-out; config and start offered mid-sweep are ignored
    set_cfg(250, 255, 10, 2, 1'b1);
    go;
    drive_cfg(99, 255, 1, 1, 1'b0);
    cfg_valid = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("c_phase", phase_inc, 250);
      chk("c_done", done, 0);
      chk("c_busy", busy, 1);
      chk("c_hop", hop_count, 0);
      tick;
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("c_abort_busy", busy, 0);
    chk("c_abort_phase", phase_inc, 250);

    // config and start in the same cycle, dwell 0 acts as 1
    drive_cfg(7, 20, 3, 0, 1'b0);
    cfg_valid = 1'b1;
    start = 1'b1;
    tick;
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("d_phase", phase_inc, 7 + 3 * (i / 2));
      chk("d_hop", hop_count, i / 2);
      chk("d_done_low", done, 0);
      tick;
    end
    chk("d_done_pulse", done, 1);
    chk("d_fin_phase", phase_inc, 19);
    chk("d_fin_hop", hop_count, 4);
    tick;

    // step 0, single sweep
    set_cfg(5, 100, 0, 3, 1'b0);
    go;
    for (int i = 0; i < 4; i++) begin
      chk("e_phase", phase_inc, 5);
      chk("e_busy", busy, 1);
      chk("e_done_low", done, 0);
      tick;
    end
    chk("e_done_pulse", done, 1);
    chk("e_fin_phase", phase_inc, 5);
    chk("e_fin_busy", busy, 0);
    chk("e_fin_hop", hop_count, 0);
    tick;

    // start above stop: one dwell then finish
    set_cfg(50, 20, 1, 1, 1'b0);
    go;
    chk("f_phase", phase_inc, 50);
    chk("f_busy", busy, 1);
    tick;
    chk("f_hop_no_done", done, 0);
    tick;
    chk("f_done_pulse", done, 1);
    chk("f_fin_phase", phase_inc, 50);
    tick;

    // asynchronous reset mid-sweep, then shadows must read back as zero
    set_cfg(3, 13, 5, 4, 1'b0);
    go;
    tick; tick;
    #3 reset_n = 1'b0;
    #1;
    chk("g_rst_phase", phase_inc, 0);
    chk("g_rst_busy", busy, 0);
    chk("g_rst_nco", nco_en, 0);
    chk("g_rst_ready", cfg_ready, 0);
    chk("g_rst_done", done, 0);
    @(posedge pll_clock);
    #1 reset_n = 1'b1;
    chk("g_ready_before", cfg_ready, 0);
    tick;
    chk("g_ready_after", cfg_ready, 1);
    chk("g_phase_after", phase_inc, 0);
    go;
    chk("g_zero_start", phase_inc, 0);
    chk("g_zero_busy", busy, 1);
    tick;
    chk("g_hop_no_done", done, 0);
    tick;
    chk("g_done_pulse", done, 1);
    chk("g_fin_phase", phase_inc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter INC_W, default 8, meaning the phase-increment width; it matches the NCO `pi` port.
REQ-002 The block SHALL have parameter DWELL_W, default 16, meaning the dwell-counter width.
REQ-003 The block SHALL have port pll_clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit: the configuration-offer strobe.
REQ-006 The block SHALL have port cfg_ready, output, 1 bit: configuration accepted this cycle when high together with cfg_valid.
REQ-007 The block SHALL have port cfg_start_inc, input, INC_W bits: the first phase increment of a sweep.
REQ-008 The block SHALL have port cfg_stop_inc, input, INC_W bits: the upper bound on the phase increment.
REQ-009 The block SHALL have port cfg_step, input, INC_W bits: the increment added per hop.
REQ-010 The block SHALL have port cfg_dwell, input, DWELL_W bits: the cycles spent per tone; 0 is treated as 1.
REQ-011 The block SHALL have port cfg_repeat, input, 1 bit: 1 means a continuous sweep, 0 means a single sweep.
REQ-012 The block SHALL have port start, input, 1 bit: a sweep-start pulse.
REQ-013 The block SHALL have port abort, input, 1 bit: a sweep-cancel pulse.
REQ-014 The block SHALL have port phase_inc, output, INC_W bits: the registered value that drives the NCO `pi` input.
REQ-015 The block SHALL have port nco_en, output, 1 bit: the registered enable that drives the NCO `clk_en` input.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a sweep is active.
REQ-017 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a single sweep completes.
REQ-018 The block SHALL have port hop_count, output, 8 bits: the number of hops taken in the current sweep, saturating at 255.

Function
REQ-019 The block SHALL have the states IDLE, DWELL, HOP and FINISH.
REQ-020 The block SHALL drive cfg_ready high only in IDLE, and SHALL capture all cfg_* fields into shadow registers on a cfg_valid&&cfg_ready cycle.
REQ-021 If start and cfg_valid are both high in IDLE in the same cycle, the block SHALL capture the new configuration and start the sweep with it.
REQ-022 On start in IDLE, the block SHALL, one cycle later, drive phase_inc=start_inc, nco_en=1, busy=1 and hop_count=0, load the dwell counter, and enter DWELL.
REQ-023 In DWELL the dwell counter SHALL decrement each cycle, so each tone is held for exactly max(dwell,1) cycles, and the block SHALL enter HOP on expiry.
REQ-024 In HOP the block SHALL compute next=phase_inc+step at INC_W+1 bits, unsigned.
REQ-025 In HOP, if step!=0 and next<=stop_inc, the block SHALL load phase_inc=next, increment hop_count (saturating at 255), reload the dwell counter and return to DWELL.
REQ-026 In HOP, if next>stop_inc, including carry-out, the block SHALL restart when repeat=1 (phase_inc=start_inc, hop_count=0, DWELL) and enter FINISH when repeat=0.
REQ-027 In HOP with step==0, the block SHALL hold the tone and re-dwell when repeat=1, and enter FINISH when repeat=0.
REQ-028 HOP SHALL last exactly one cycle, so a new tone appears on phase_inc dwell+1 cycles after the previous one.
REQ-029 If start_inc>stop_inc, the block SHALL dwell once at start_inc and then behave per REQ-026.
REQ-030 In FINISH the block SHALL pulse done for one cycle, drive nco_en=0 and busy=0, return to IDLE, and hold phase_inc at its last value.
REQ-031 An abort in any non-IDLE state SHALL, one cycle later, put the block in IDLE with nco_en=0 and busy=0, phase_inc held and no done pulse; abort SHALL take priority over every other transition.
REQ-032 The block SHALL ignore start while not in IDLE and ignore abort while in IDLE.
REQ-033 The block SHALL not alter shadow registers during a sweep.

Reset
REQ-034 While reset_n is low, the block SHALL immediately force state=IDLE, phase_inc=0, nco_en=0, busy=0, done=0, cfg_ready=0, hop_count=0, and shadow registers to 0.
REQ-035 The block SHALL raise cfg_ready on the first pll_clock edge after reset_n rises.
REQ-036 Reset asserted mid-sweep SHALL cancel the sweep without a done pulse.

Structure
REQ-037 The shared package freq_sweep_pkg SHALL hold the state encoding and the default INC_W and DWELL_W constants.
REQ-038 The dwell timer SHALL be one sub-module, dwell_timer (load, value, expire pulse), and the rest SHALL be a single FSM module.

Verification
REQ-039 Configure start=3, stop=13, step=5, dwell=4, repeat=0, then start -> phase_inc SHALL be 3, 8, 13, each held 4 cycles with a 1-cycle HOP between tones; done SHALL pulse once; hop_count SHALL end at 2; phase_inc SHALL hold 13.
REQ-040 Configure start=250, stop=255, step=10, repeat=1 -> the carry-out SHALL be detected, phase_inc SHALL return to 250 after each dwell, and done SHALL never assert.
REQ-041 Issue abort in the second DWELL of the REQ-039 setup -> one cycle later busy=0, nco_en=0 and phase_inc=8, with no done pulse.
REQ-042 Assert cfg_valid and start in the same IDLE cycle with start=7 and dwell=0 -> phase_inc SHALL be 7 with each tone held 1 cycle.
REQ-043 Assert reset_n low mid-sweep asynchronously (between edges) -> outputs SHALL reach their reset values without waiting for a clock edge, and cfg_ready SHALL be 1 one edge after release.
REQ-044 Configure step=0, repeat=0, dwell=3 -> the block SHALL dwell 3 cycles, then HOP, then FINISH with done pulsed and phase_inc equal to start.
